pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal range 4..64.
REQ-002 Parameter STAGES, default 2: number of register stages; legal range 1..4; WIDTH >= 2*STAGES.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry in; ignored when op_sub=1.
REQ-010 op_sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts a result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out; for subtract, 1 means no borrow.

Function
REQ-015 Add: {c_out,sum} = a_in + b_in + c_in, truncated to WIDTH+1 bits.
REQ-016 Subtract: {c_out,sum} = a_in + ~b_in + 1, truncated to WIDTH+1 bits.
REQ-017 Slice split: the carry chain is split into STAGES slices of floor(WIDTH/STAGES) bits; the top slice also takes the remainder bits.
REQ-018 Slice k is added in stage k.
- Its carry is registered into stage k+1.
- Completed lower slices and unprocessed upper operand slices are registered alongside it.
REQ-019 Transfer rule: a beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-020 Latency: exactly STAGES cycles from input transfer to out_valid, when not stalled.
REQ-021 Throughput: one beat per cycle.
REQ-022 Advance condition: the pipeline advances as a whole when (!out_valid || out_ready).
REQ-023 in_ready equals the advance condition, combinationally.
REQ-024 Stall: while the pipeline does not advance, all stage registers and outputs hold.
- No beat is dropped or duplicated.
- Beat order is preserved.
REQ-025 Bubbles: a stage with no valid beat still advances, so it can be overwritten; its valid bit propagates 0.
REQ-026 Output stability: sum and c_out are stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured.
- Occupancy stays unchanged.
REQ-028 STAGES=1: a single registered full-width add.
- in_ready = !out_valid || out_ready.

Reset
REQ-029 While rst_n=0, all stage valid bits, out_valid, sum and c_out are 0, independent of clk.
REQ-030 in_ready is 1 while rst_n=0.
REQ-031 Reset mid-operation discards all in-flight beats; no result is emitted for them after release.
REQ-032 First transfer after reset: rst_n is deasserted synchronously to clk; the first beat may transfer on the first rising edge after deassertion.

Configuration
REQ-033 Macro PIPE_ADDER_OVF_EN, when defined, adds output port ovf (1 bit).
- ovf = signed two's-complement overflow of the operation.
- ovf travels with the beat and resets to 0.
REQ-034 Without PIPE_ADDER_OVF_EN, port ovf does not exist; all other behaviour is identical.

Verification
All scenarios use WIDTH=16, STAGES=2 unless stated otherwise.
REQ-035 Carry across slices: a=0xFFFF, b=0x0001, c_in=0, add, out_ready=1 -> 2 cycles later: out_valid=1, sum=0x0000, c_out=1.
REQ-036 Subtract with borrow: a=0x0005, b=0x0007, op_sub=1 -> sum=0xFFFE, c_out=0; with OVF_EN, ovf=0.
REQ-037 Signed overflow (OVF_EN): a=0x7FFF, b=0x0001, add -> sum=0x8000, c_out=0, ovf=1.
REQ-038 Backpressure:
- Stimulus: stream 6 beats (a=i, b=0x0100) back-to-back; hold out_ready=0 for 3 cycles after the first result.
- Response: in_ready=0 during the hold; sum=0x0100..0x0105 in order, none lost.
REQ-039 Reset mid-operation: 2 beats in flight, pulse rst_n low for 1 cycle -> out_valid=0 immediately; no output for those beats; the next beat's result appears 2 cycles after its acceptance.
REQ-040 Parameter sweep: WIDTH=13, STAGES=3, 10000 random add/sub beats with random out_ready -> every result matches the REQ-015/016 model.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with the carry chain split into STAGES slices, one slice per stage.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SliceW = WIDTH / STAGES;

    logic advance;

    // Whole pipeline moves together; empty stages advance too, so bubbles get overwritten.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Lo   = k * SliceW;
        localparam int unsigned RemW = WIDTH - Lo;
        localparam bit          Last = (k == STAGES - 1);
        localparam int unsigned SW   = Last ? RemW : SliceW;

        // Operand bits not yet consumed: slice k sits in the low SW bits.
        logic [RemW-1:0]    a_src;
        logic [RemW-1:0]    b_src;
        logic               c_src;
        logic               v_src;
        logic [SW:0]        t;
        logic [Lo+SW-1:0]   s_d;
        logic [Lo+SW-1:0]   s_q;
        logic               c_q;
        logic               v_q;

        if (k == 0) begin : g_in
            assign a_src = a_in;
            assign b_src = op_sub ? ~b_in : b_in;
            assign c_src = op_sub | c_in;
            assign v_src = in_valid;
            assign s_d   = t[SW-1:0];
        end else begin : g_mid
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_d   = {t[SW-1:0], g_stage[k-1].s_q};
        end

        assign t = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_src};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_src;
                c_q <= t[SW];
                s_q <= s_d;
            end
        end

        if (!Last) begin : g_fwd
            logic [RemW-SW-1:0] a_q;
            logic [RemW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[RemW-1:SW];
                    b_q <= b_src[RemW-1:SW];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (Last) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // b_src is already inverted for subtract, so one rule covers both operations.
            assign ovf_d = (a_src[RemW-1] == b_src[RemW-1]) && (t[SW-1] != a_src[RemW-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign c_out     = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: two instances (16/2 and 13/3), directed literals plus random traffic
// checked against an arithmetic model with a queue of in-flight beats.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned W     = (g == 0) ? 16 : 13;
        localparam int unsigned S     = (g == 0) ? 2 : 3;
        localparam int unsigned NRand = (g == 0) ? 3000 : 10000;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a_in;
        logic [W-1:0] b_in;
        logic         c_in;
        logic         op_sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf_o;
        bit           done = 1'b0;

        pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a_in      (a_in),
            .b_in      (b_in),
            .c_in      (c_in),
            .op_sub    (op_sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out)
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf       (ovf_o)
`endif
        );
`ifndef PIPE_ADDER_OVF_EN
        assign ovf_o = 1'b0;
`endif

        // Reference: {ovf, c_out, sum} from plain integer arithmetic.
        function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic sub);
            longint ua, ub, sa, sb, full, sr, maxs;
            logic   v;
            ua   = longint'(a);
            ub   = longint'(b);
            sa   = a[W-1] ? ua - (longint'(1) << W) : ua;
            sb   = b[W-1] ? ub - (longint'(1) << W) : ub;
            maxs = (longint'(1) << (W - 1)) - 1;
            if (sub) begin
                full = ua - ub + (longint'(1) << W);
                sr   = sa - sb;
            end else begin
                full = ua + ub + longint'(c);
                sr   = sa + sb + longint'(c);
            end
            v = (sr > maxs) || (sr < -maxs - 1);
            return {v, full[W], full[W-1:0]};
        endfunction

        logic [W+1:0] q_res[$];
        int unsigned  q_st[$];
        int unsigned  adv_cnt = 0;
        string        pfx;
        initial pfx = $sformatf("c%0d_", g);

        // Per-cycle compare and prediction of the next edge.
        always @(negedge clk) begin
            logic exp_v;
            logic adv;
            if (!rst_n) begin
                q_res.delete();
                q_st.delete();
                chk({pfx, "rst_out_valid"}, out_valid, 0);
                chk({pfx, "rst_sum"}, sum, 0);
                chk({pfx, "rst_c_out"}, c_out, 0);
                chk({pfx, "rst_in_ready"}, in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
                chk({pfx, "rst_ovf"}, ovf_o, 0);
`endif
            end else begin
                exp_v = (q_st.size() > 0) && (adv_cnt - q_st[0] == S);
                chk({pfx, "out_valid"}, out_valid, exp_v);
                chk({pfx, "in_ready"}, in_ready, !exp_v || out_ready);
                if (exp_v) begin
                    chk({pfx, "sum"}, sum, q_res[0][W-1:0]);
                    chk({pfx, "c_out"}, c_out, q_res[0][W]);
`ifdef PIPE_ADDER_OVF_EN
                    chk({pfx, "ovf"}, ovf_o, q_res[0][W+1]);
`endif
                end
                adv = !exp_v || out_ready;
                if (exp_v && out_ready) begin
                    void'(q_res.pop_front());
                    void'(q_st.pop_front());
                end
                if (in_valid && adv) begin
                    q_res.push_back(model(a_in, b_in, c_in, op_sub));
                    q_st.push_back(adv_cnt);
                end
                if (adv) adv_cnt++;
            end
        end

        // One beat with out_ready=1 into an empty pipe; result expected S edges after accept.
        task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic sub, input logic [W-1:0] e_sum,
                                input logic e_c, input logic e_ovf);
            @(posedge clk); #1;
            out_ready = 1'b1;
            a_in = a; b_in = b; c_in = c; op_sub = sub; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (S - 1) @(posedge clk);
            @(negedge clk);
            chk({pfx, name, "_valid"}, out_valid, 1);
            chk({pfx, name, "_sum"}, sum, e_sum);
            chk({pfx, name, "_c_out"}, c_out, e_c);
`ifdef PIPE_ADDER_OVF_EN
            chk({pfx, name, "_ovf"}, ovf_o, e_ovf);
`else
            if (e_ovf !== 1'bx) ;
`endif
        endtask

        initial begin
            logic [W-1:0] ones;
            logic [W-1:0] maxpos;
            logic [W-1:0] minneg;
            int sent, got, hold, guard, acc, cyc;
            bit seen, holding;
            ones   = '1;
            maxpos = ones >> 1;
            minneg = ~maxpos;
            rst_n = 1'b1;
            in_valid = 1'b0; out_ready = 1'b1;
            a_in = '0; b_in = '0; c_in = 1'b0; op_sub = 1'b0;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            directed("carry", ones, 1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
            directed("borrow", 5, 7, 1'b0, 1'b1, ones - 1, 1'b0, 1'b0);
            directed("sovf", maxpos, 1, 1'b0, 1'b0, minneg, 1'b0, 1'b1);
            directed("cin", 3, 4, 1'b1, 1'b0, 8, 1'b0, 1'b0);

            // Backpressure: 6 beats, out_ready low for 3 cycles once the first result shows.
            @(posedge clk); #1;
            sent = 0; got = 0; hold = 0; guard = 0; seen = 0;
            b_in = 'h100; c_in = 1'b0; op_sub = 1'b0;
            while (got < 6 && guard < 100) begin
                if (out_valid && !seen) begin
                    seen = 1;
                    hold = 3;
                end
                holding   = (hold > 0);
                out_ready = !holding;
                if (hold > 0) hold--;
                in_valid = (sent < 6);
                a_in     = W'(sent);
                @(negedge clk);
                if (holding) chk({pfx, "bp_in_ready_hold"}, in_ready, 0);
                if (out_valid && out_ready) begin
                    chk({pfx, "bp_sum"}, sum, 'h100 + got);
                    got++;
                end
                if (in_valid && in_ready) sent++;
                @(posedge clk); #1;
                guard++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk({pfx, "bp_count"}, got, 6);

            // Reset with two beats in flight.
            repeat (S + 1) @(posedge clk);
            #1;
            a_in = 1; b_in = 1; in_valid = 1'b1;
            @(posedge clk); #1;
            a_in = 2;
            @(posedge clk); #1;
            in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk({pfx, "rst_now_valid"}, out_valid, 0);
            chk({pfx, "rst_now_sum"}, sum, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int i = 0; i < S + 2; i++) begin
                @(negedge clk);
                chk({pfx, "rst_no_stale"}, out_valid, 0);
            end
            directed("after_rst", 9, 6, 1'b0, 1'b0, 15, 1'b0, 1'b0);

            // Random traffic.
            @(posedge clk); #1;
            acc = 0; cyc = 0;
            while (acc < NRand && cyc < 60000) begin
                in_valid  = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
                a_in      = W'($urandom);
                b_in      = W'($urandom);
                c_in      = $urandom_range(1) == 1;
                op_sub    = $urandom_range(1) == 1;
                @(negedge clk);
                if (in_valid && in_ready) acc++;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk({pfx, "rand_accepted"}, acc, NRand);
            repeat (S + 2) @(posedge clk);
            @(negedge clk);
            chk({pfx, "drained"}, q_st.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_cfg[0].done && g_cfg[1].done);
            #2000000;
        join_any
        disable fork;
        chk("all_done", g_cfg[0].done && g_cfg[1].done, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
